nrc_burst_rd: RTL
=================

# nrc_burst_rd

Parametrised network read controller for the fully-connected datapath. It fetches the bias, weight and data tensors of one layer from the shared bus using multi-beat read bursts. Each tensor is packed into a flat output buffer and presented to the fully-connected unit under a valid/ready handshake. It sits between fc_ctrl, which supplies the per-tensor base addresses, the bus read channel, and the fully-connected compute unit.

## Interface
Parameters:
- BATCH_SIZE, 1, batch rows in the data tensor
- FEATURE_SIZE, 1, features per row
- BIAS_SIZE, 1, output neurons
- BURST_LEN, 16, maximum beats per burst; legal range 1..16
- ARID, 4'b1001, read ID driven on aruserid and matched on rid
- ADDR_W, 28, word address width

Derived sizes, in 32-bit words:
- DSZ = BATCH_SIZE*FEATURE_SIZE
- WSZ = FEATURE_SIZE*BIAS_SIZE
- BSZ = BIAS_SIZE

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- NcNrc_start  in  1  start-layer pulse
- NrcNc_initAddrRq  out  1  request base address for the current tensor
- NrcNc_dataType  out  3  current tensor: 001 data, 010 weight, 100 bias
- NcNrc_initAddr  in  ADDR_W  base word address
- NcNrc_initAddrEn  in  1  base address valid
- NrcNc_rd_end  out  1  one-cycle pulse when all three tensors are loaded
- NrcNc_err  out  1  sticky protocol error
- NrcBus_arvalid  out  1  read address valid
- NrcBus_aruserid  out  4  read ID, equal to ARID
- NrcBus_arlen  out  4  beats-1
- NrcBus_aruserap  out  1  tied 1 while arvalid
- NrcBus_araddr  out  ADDR_W  burst start word address
- BusNrc_arready  in  1  address accepted
- BusNrc_rvalid  in  1  read beat valid
- BusNrc_rlast  in  1  last beat of burst
- BusNrc_rid  in  4  beat ID
- BusNrc_rdata  in  32  beat data
- NrcFc_data  out  DSZ*32  word i at bits [32i+31:32i]
- NrcFc_weight  out  WSZ*32  same packing
- NrcFc_bias  out  BSZ*32  same packing
- NrcFc_valid  out  1  all three tensors are held valid
- FcNrc_ready  in  1  consumer takes the tensors

## Operation
- Tensor order: bias, then weight, then data.
- States:
  - IDLE: waits for NcNrc_start; NcNrc_start while not IDLE is ignored.
  - ADDR_RQ: initAddrRq=1; on initAddrEn, capture the address, clear the word count, go to AR.
  - AR: arvalid=1 with araddr=addr, arlen=min(BURST_LEN, remaining)-1; on arvalid&arready go to RD.
  - RD: accept beats with rvalid && rid==ARID; other beats are ignored. Beat k of the tensor is written to word slot k. At the burst's final beat, addr += beats and go to NEXT.
  - NEXT: if remaining>0 go to AR; else if the tensor is bias or weight, advance dataType and go to ADDR_RQ; else pulse rd_end and go to HOLD.
  - HOLD: NrcFc_valid=1; on FcNrc_ready, clear valid and go to IDLE.
- Remaining = tensor size - word count. The word counter is wide enough for max(DSZ,WSZ,BSZ).
- Address arithmetic wraps modulo 2^ADDR_W; no error is raised on wrap.
- Buffers retain their contents in IDLE; each slot is overwritten only by its new beat.
- dataType is valid in every state except IDLE, where it reads 000.

## Timing
- Reset: every output is 0 and the state is IDLE; all buffers are cleared. Reset mid-burst abandons the transfer; beats arriving after reset are ignored.
- start→initAddrRq: 1 cycle.
- initAddrEn→arvalid: 1 cycle.
- arvalid is held until arready. arready is only sampled while arvalid=1, so a same-cycle handshake completes in 1 cycle.
- A beat's data is visible on the output buffer the cycle after it is accepted.
- Last beat→next arvalid: 2 cycles (via NEXT).
- rd_end and NrcFc_valid rise in the same cycle.
- If FcNrc_ready is already high on entering HOLD, valid is high for exactly 1 cycle.

## Configuration
- NRC_RLAST_CHECK_EN defined:
  - A burst ends on the expected beat count.
  - rlast on a non-final beat, or missing rlast on the final beat, sets NrcNc_err, which is sticky until rst.
  - Data is still stored.
- NRC_RLAST_CHECK_EN undefined: rlast is ignored, burst length is counted only, and NrcNc_err is tied 0.

## Structure
- Package nrc_pkg:
  - state enum
  - dataType codes DT_DATA/DT_WEIGHT/DT_BIAS
  - ARID default
  - MAX_BURST=16
  - function min_beats(remaining, BURST_LEN)
- Sub-module nrc_pack_buf: parametrised word-slot register file (DEPTH, write enable, write index, write data, flat output). It is instantiated three times.

## Test plan
- BATCH=2, FEATURE=3, BIAS=2, BURST_LEN=4; bases 0x100/0x200/0x300 → one bias burst: arlen=1 @0x100. Weight bursts: arlen=3 @0x200, then arlen=1 @0x204. Data bursts: arlen=3 @0x300, then arlen=1 @0x304. rd_end pulses once; buffers hold beat values in order.
- Beats with rid=4'b0011 interleaved during RD → ignored; buffers are unchanged in those slots.
- arready held low for 5 cycles → arvalid and araddr stay stable all 5 cycles; a single transfer occurs.
- FcNrc_ready low for 10 cycles in HOLD → NrcFc_valid stays high; it drops the cycle after ready; NcNrc_start during HOLD is ignored.
- rst asserted after the second weight beat → all outputs 0 the next cycle; a new start refetches from bias.
- With NRC_RLAST_CHECK_EN: rlast on beat 2 of a 4-beat burst → NrcNc_err=1 and held; the transfer completes. Without the macro: err stays 0.

Source files
------------

// File: rtl/nrc_pkg.sv
// Shared types and constants for the network read controller (nrc_burst_rd).
package nrc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_RQ,
    ST_AR,
    ST_RD,
    ST_NEXT,
    ST_HOLD
  } nrc_state_t;

  // One-hot tensor codes presented on NrcNc_dataType.
  localparam logic [2:0] DT_DATA   = 3'b001;
  localparam logic [2:0] DT_WEIGHT = 3'b010;
  localparam logic [2:0] DT_BIAS   = 3'b100;

  localparam logic [3:0]  ARID_DEFAULT = 4'b1001;
  localparam int unsigned MAX_BURST    = 16;

  // Beats in the next burst: whatever is left, capped at the burst length.
  function automatic int unsigned min_beats(input int unsigned remaining,
                                            input int unsigned burstLen);
    return (remaining < burstLen) ? remaining : burstLen;
  endfunction

endpackage

// File: rtl/nrc_burst_rd_buf.sv
// nrc_pack_buf: word-slot register file with a flat packed output.
// Slot i lives at flat[32i+31:32i]; a write touches only the addressed slot.
module nrc_pack_buf #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned IDX_W = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      wrIdx,
  input  logic [31:0]           wrData,
  output logic [DEPTH*32-1:0]   flat
);

  // Clear on reset, otherwise overwrite only the addressed slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      flat <= '0;
    end else if (we) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wrIdx == IDX_W'(i)) begin
          flat[32*i +: 32] <= wrData;
        end
      end
    end
  end

endmodule

// File: rtl/nrc_burst_rd.sv
// nrc_burst_rd: fetches the bias, weight and data tensors of one layer with
// multi-beat read bursts and presents them to the fully-connected unit.
// Optional feature macro: NRC_RLAST_CHECK_EN (rlast consistency check driving
// a sticky NrcNc_err; when undefined rlast is ignored and NrcNc_err is 0).
module nrc_burst_rd
  import nrc_pkg::*;
#(
  parameter int unsigned BATCH_SIZE   = 1,
  parameter int unsigned FEATURE_SIZE = 1,
  parameter int unsigned BIAS_SIZE    = 1,
  parameter int unsigned BURST_LEN    = 16,
  parameter logic [3:0]  ARID         = ARID_DEFAULT,
  parameter int unsigned ADDR_W       = 28
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               NcNrc_start,
  output logic                               NrcNc_initAddrRq,
  output logic [2:0]                         NrcNc_dataType,
  input  logic [ADDR_W-1:0]                  NcNrc_initAddr,
  input  logic                               NcNrc_initAddrEn,
  output logic                               NrcNc_rd_end,
  output logic                               NrcNc_err,
  output logic                               NrcBus_arvalid,
  output logic [3:0]                         NrcBus_aruserid,
  output logic [3:0]                         NrcBus_arlen,
  output logic                               NrcBus_aruserap,
  output logic [ADDR_W-1:0]                  NrcBus_araddr,
  input  logic                               BusNrc_arready,
  input  logic                               BusNrc_rvalid,
  input  logic                               BusNrc_rlast,
  input  logic [3:0]                         BusNrc_rid,
  input  logic [31:0]                        BusNrc_rdata,
  output logic [BATCH_SIZE*FEATURE_SIZE*32-1:0] NrcFc_data,
  output logic [FEATURE_SIZE*BIAS_SIZE*32-1:0]  NrcFc_weight,
  output logic [BIAS_SIZE*32-1:0]               NrcFc_bias,
  output logic                               NrcFc_valid,
  input  logic                               FcNrc_ready
);

  localparam int unsigned DSZ   = BATCH_SIZE * FEATURE_SIZE;
  localparam int unsigned WSZ   = FEATURE_SIZE * BIAS_SIZE;
  localparam int unsigned BSZ   = BIAS_SIZE;
  localparam int unsigned MAXDW = (DSZ > WSZ) ? DSZ : WSZ;
  localparam int unsigned MAXSZ = (MAXDW > BSZ) ? MAXDW : BSZ;
  localparam int unsigned CNT_W = $clog2(MAXSZ + 1);

  nrc_state_t         state, stateNxt;
  logic [2:0]         dtReg, dtNxt;
  logic [ADDR_W-1:0]  addr, addrNxt;
  logic [CNT_W-1:0]   wordCnt, wordCntNxt;
  logic [4:0]         beatCnt, beatCntNxt;
  logic [4:0]         burstBeats, burstBeatsNxt;
  logic               rdEndQ, rdEndNxt;

  logic [CNT_W-1:0]   tensorSize;
  logic [CNT_W-1:0]   remaining;
  logic [4:0]         curBeats;
  logic               beatAcc;
  logic               finalBeat;

  // Size of the tensor currently being fetched and the beats of its next burst.
  always_comb begin
    tensorSize = CNT_W'(DSZ);
    case (dtReg)
      DT_BIAS:   tensorSize = CNT_W'(BSZ);
      DT_WEIGHT: tensorSize = CNT_W'(WSZ);
      default:   tensorSize = CNT_W'(DSZ);
    endcase
    remaining = tensorSize - wordCnt;
    curBeats  = 5'(min_beats(32'(remaining), BURST_LEN));
  end

  assign beatAcc   = (state == ST_RD) && BusNrc_rvalid && (BusNrc_rid == ARID);
  assign finalBeat = (beatCnt == burstBeats - 5'd1);

  // Next-state and next-register values for the fetch sequencer.
  always_comb begin
    stateNxt      = state;
    dtNxt         = dtReg;
    addrNxt       = addr;
    wordCntNxt    = wordCnt;
    beatCntNxt    = beatCnt;
    burstBeatsNxt = burstBeats;
    rdEndNxt      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (NcNrc_start) begin
          dtNxt    = DT_BIAS;
          stateNxt = ST_ADDR_RQ;
        end
      end
      ST_ADDR_RQ: begin
        if (NcNrc_initAddrEn) begin
          addrNxt    = NcNrc_initAddr;
          wordCntNxt = '0;
          stateNxt   = ST_AR;
        end
      end
      ST_AR: begin
        if (BusNrc_arready) begin
          burstBeatsNxt = curBeats;
          beatCntNxt    = '0;
          stateNxt      = ST_RD;
        end
      end
      ST_RD: begin
        if (beatAcc) begin
          wordCntNxt = wordCnt + CNT_W'(1);
          beatCntNxt = beatCnt + 5'd1;
          if (finalBeat) begin
            addrNxt  = addr + ADDR_W'(burstBeats);
            stateNxt = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        if (remaining != '0) begin
          stateNxt = ST_AR;
        end else if (dtReg == DT_BIAS) begin
          dtNxt    = DT_WEIGHT;
          stateNxt = ST_ADDR_RQ;
        end else if (dtReg == DT_WEIGHT) begin
          dtNxt    = DT_DATA;
          stateNxt = ST_ADDR_RQ;
        end else begin
          rdEndNxt = 1'b1;
          stateNxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (FcNrc_ready) begin
          stateNxt = ST_IDLE;
        end
      end
      default: stateNxt = ST_IDLE;
    endcase
  end

  // Sequencer registers; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      dtReg      <= '0;
      addr       <= '0;
      wordCnt    <= '0;
      beatCnt    <= '0;
      burstBeats <= '0;
      rdEndQ     <= 1'b0;
    end else begin
      state      <= stateNxt;
      dtReg      <= dtNxt;
      addr       <= addrNxt;
      wordCnt    <= wordCntNxt;
      beatCnt    <= beatCntNxt;
      burstBeats <= burstBeatsNxt;
      rdEndQ     <= rdEndNxt;
    end
  end

  assign NrcNc_initAddrRq = (state == ST_ADDR_RQ);
  assign NrcNc_dataType   = (state == ST_IDLE) ? 3'b000 : dtReg;
  assign NrcNc_rd_end     = rdEndQ;
  assign NrcFc_valid      = (state == ST_HOLD);
  assign NrcBus_arvalid   = (state == ST_AR);
  assign NrcBus_aruserap  = NrcBus_arvalid;
  assign NrcBus_aruserid  = NrcBus_arvalid ? ARID : 4'b0000;
  assign NrcBus_arlen     = NrcBus_arvalid ? 4'(curBeats - 5'd1) : 4'b0000;
  assign NrcBus_araddr    = NrcBus_arvalid ? addr : '0;

`ifdef NRC_RLAST_CHECK_EN
  logic errQ;

  // Sticky flag: rlast must coincide exactly with the counted final beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      errQ <= 1'b0;
    end else if (beatAcc && (BusNrc_rlast != finalBeat)) begin
      errQ <= 1'b1;
    end
  end

  assign NrcNc_err = errQ;
`else
  logic unusedRlast;
  assign unusedRlast = BusNrc_rlast;
  assign NrcNc_err   = 1'b0;
`endif

  nrc_pack_buf #(.DEPTH(BSZ), .IDX_W(CNT_W)) uBiasBuf (
    .clk    (clk),
    .rst    (rst),
    .we     (beatAcc && (dtReg == DT_BIAS)),
    .wrIdx  (wordCnt),
    .wrData (BusNrc_rdata),
    .flat   (NrcFc_bias)
  );

  nrc_pack_buf #(.DEPTH(WSZ), .IDX_W(CNT_W)) uWeightBuf (
    .clk    (clk),
    .rst    (rst),
    .we     (beatAcc && (dtReg == DT_WEIGHT)),
    .wrIdx  (wordCnt),
    .wrData (BusNrc_rdata),
    .flat   (NrcFc_weight)
  );

  nrc_pack_buf #(.DEPTH(DSZ), .IDX_W(CNT_W)) uDataBuf (
    .clk    (clk),
    .rst    (rst),
    .we     (beatAcc && (dtReg == DT_DATA)),
    .wrIdx  (wordCnt),
    .wrData (BusNrc_rdata),
    .flat   (NrcFc_data)
  );

endmodule
